// File: rtl/risk_arbiter.sv
// Round-robin front end that shares one risk engine among N strategy cores.
// Holds a sticky halt on any kill verdict or engine timeout.
module risk_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*32-1:0]      req_position,
  input  logic [N_REQ*32-1:0]      req_beta,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic                     rsp_allow,
  output logic                     rsp_kill,
  output logic                     eng_in_valid,
  input  logic                     eng_in_ready,
  output logic [31:0]              eng_position,
  output logic [31:0]              eng_beta,
  input  logic                     eng_out_valid,
  output logic                     eng_out_ready,
  input  logic                     eng_allow,
  input  logic                     eng_kill,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     halt,
  output logic                     timeout_err,
  input  logic                     clear_halt
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DELIVER
  } state_e;

  state_e        state_q;
  logic [IW-1:0] last_q, grant_q, win_idx;
  logic [31:0]   pos_q, beta_q, pos_sel, beta_sel;
  logic [CW-1:0] cnt_q;
  logic          allow_q, kill_q, halt_q, terr_q;
  logic          win_found, take, rsp_hit, tmo_hit, kill_set;
  logic [31:0]   j;

  // search starts just after the last owner and wraps
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (32'(last_q) + 32'(k)) % 32'(N_REQ);
      if (!win_found && req_valid[j[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = j[IW-1:0];
      end
    end
  end

  always_comb begin
    pos_sel  = '0;
    beta_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        pos_sel  = req_position[32*i +: 32];
        beta_sel = req_beta[32*i +: 32];
      end
    end
  end

  assign req_ready = (state_q == IDLE && !halt_q && win_found)
                     ? (N_REQ'(1) << win_idx) : '0;
  assign take      = |req_ready;

  assign rsp_hit  = (state_q == WAIT) && eng_out_valid;
  assign tmo_hit  = (state_q == ISSUE ||
                     (state_q == WAIT && !eng_out_valid)) &&
                    (cnt_q == CW'(TIMEOUT - 1));
  assign kill_set = (rsp_hit && eng_kill) || tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(N_REQ - 1);
      grant_q <= '0;
      pos_q   <= '0;
      beta_q  <= '0;
      cnt_q   <= '0;
      allow_q <= 1'b0;
      kill_q  <= 1'b0;
      halt_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            pos_q   <= pos_sel;
            beta_q  <= beta_sel;
            grant_q <= win_idx;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (tmo_hit) begin
            allow_q <= 1'b0;
            kill_q  <= 1'b1;
            state_q <= DELIVER;
          end else if (eng_in_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (rsp_hit) begin
            allow_q <= eng_allow;
            kill_q  <= eng_kill;
            state_q <= DELIVER;
          end else if (tmo_hit) begin
            allow_q <= 1'b0;
            kill_q  <= 1'b1;
            state_q <= DELIVER;
          end
        end
        DELIVER: begin
          if (rsp_ready[grant_q]) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // a set in the same cycle as a clear wins
      if (kill_set)        halt_q <= 1'b1;
      else if (clear_halt) halt_q <= 1'b0;
      if (tmo_hit)         terr_q <= 1'b1;
      else if (clear_halt) terr_q <= 1'b0;
    end
  end

  assign rsp_valid     = (state_q == DELIVER) ? (N_REQ'(1) << grant_q) : '0;
  assign rsp_allow     = allow_q;
  assign rsp_kill      = kill_q;
  assign eng_in_valid  = (state_q == ISSUE);
  assign eng_out_ready = (state_q == IDLE) || (state_q == WAIT);
  assign eng_position  = pos_q;
  assign eng_beta      = beta_q;
  assign grant_id      = grant_q;
  assign halt          = halt_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_risk_arbiter.sv
// Directed-vector bench for risk_arbiter: grant order, verdict routing,
// halt/timeout behaviour and handshake stability.
module tb_risk_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_position;
  logic [127:0] req_beta;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic         rsp_allow, rsp_kill;
  logic         eng_in_valid, eng_in_ready;
  logic [31:0]  eng_position, eng_beta;
  logic         eng_out_valid, eng_out_ready;
  logic         eng_allow, eng_kill;
  logic [1:0]   grant_id;
  logic         halt, timeout_err, clear_halt;

  int n_vec = 0;
  int n_err = 0;

  risk_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_position (req_position),
    .req_beta     (req_beta),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_allow    (rsp_allow),
    .rsp_kill     (rsp_kill),
    .eng_in_valid (eng_in_valid),
    .eng_in_ready (eng_in_ready),
    .eng_position (eng_position),
    .eng_beta     (eng_beta),
    .eng_out_valid(eng_out_valid),
    .eng_out_ready(eng_out_ready),
    .eng_allow    (eng_allow),
    .eng_kill     (eng_kill),
    .grant_id     (grant_id),
    .halt         (halt),
    .timeout_err  (timeout_err),
    .clear_halt   (clear_halt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0; rsp_ready = '0; req_position = '0; req_beta = '0;
    eng_in_ready = 0; eng_out_valid = 0; eng_allow = 0; eng_kill = 0;
    clear_halt = 0;
    apply_reset();
    #1;
    n_vec++;
    if (rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid);
    end
    n_vec++;
    if (eng_in_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_eng_in_valid got %b want 0", eng_in_valid);
    end
    n_vec++;
    if (halt !== 1'b0 || timeout_err !== 1'b0) begin
      n_err++; $display("FAIL reset_halt got %b/%b want 0/0", halt, timeout_err);
    end
    n_vec++;
    if (grant_id !== 2'd0) begin
      n_err++; $display("FAIL reset_grant_id got %0d want 0", grant_id);
    end
    n_vec++;
    if (req_ready !== 4'b0000 || rsp_allow !== 1'b0 || rsp_kill !== 1'b0) begin
      n_err++;
      $display("FAIL reset_misc got rdy=%b a=%b k=%b want 0000/0/0",
               req_ready, rsp_allow, rsp_kill);
    end
  endtask

  task automatic test_first_grant();
    req_position[64 +: 32] = 32'h0001_0000;
    req_beta[64 +: 32]     = 32'h0000_8000;
    req_valid = 4'b0100;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL first_req_ready got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0; eng_in_ready = 1;
    #1;
    n_vec++;
    if (eng_in_valid !== 1'b1 || eng_position !== 32'h0001_0000 ||
        eng_beta !== 32'h0000_8000) begin
      n_err++;
      $display("FAIL first_issue got v=%b p=%h b=%h want 1/00010000/00008000",
               eng_in_valid, eng_position, eng_beta);
    end
    n_vec++;
    if (grant_id !== 2'd2) begin
      n_err++; $display("FAIL first_grant_id got %0d want 2", grant_id);
    end
    tick();
    eng_in_ready = 0; eng_out_valid = 1; eng_allow = 1; eng_kill = 0;
    #1;
    n_vec++;
    if (eng_out_ready !== 1'b1) begin
      n_err++; $display("FAIL first_out_ready got %b want 1", eng_out_ready);
    end
    tick();
    eng_out_valid = 0;
    #1;
    n_vec++;
    if (rsp_valid !== 4'b0100 || rsp_allow !== 1'b1 || rsp_kill !== 1'b0) begin
      n_err++;
      $display("FAIL first_rsp got v=%b a=%b k=%b want 0100/1/0",
               rsp_valid, rsp_allow, rsp_kill);
    end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    #1;
    n_vec++;
    if (rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL first_rsp_done got %b want 0000", rsp_valid);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] oh;
    apply_reset();
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    eng_in_ready = 1; eng_out_valid = 1; eng_allow = 1; eng_kill = 0;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      #1;
      n_vec++;
      if (req_ready !== oh) begin
        n_err++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, oh);
      end
      tick();
      #1;
      n_vec++;
      if (grant_id !== 2'(k % 4)) begin
        n_err++; $display("FAIL rr_grant[%0d] got %0d want %0d", k, grant_id, k % 4);
      end
      tick();
      tick();
      #1;
      n_vec++;
      if (rsp_valid !== oh || rsp_allow !== 1'b1) begin
        n_err++;
        $display("FAIL rr_rsp[%0d] got %b a=%b want %b a=1", k, rsp_valid, rsp_allow, oh);
      end
      tick();
    end
    req_valid = '0; rsp_ready = '0;
    eng_in_ready = 0; eng_out_valid = 0; eng_allow = 0;
    tick();
  endtask

  task automatic test_kill_halt();
    req_valid = 4'b0010;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL kill_req_ready got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0; eng_in_ready = 1;
    tick();
    eng_in_ready = 0; eng_out_valid = 1; eng_allow = 0; eng_kill = 1;
    tick();
    eng_out_valid = 0; eng_kill = 0;
    #1;
    n_vec++;
    if (rsp_valid !== 4'b0010 || rsp_kill !== 1'b1 || rsp_allow !== 1'b0) begin
      n_err++;
      $display("FAIL kill_rsp got v=%b a=%b k=%b want 0010/0/1",
               rsp_valid, rsp_allow, rsp_kill);
    end
    n_vec++;
    if (halt !== 1'b1) begin
      n_err++; $display("FAIL kill_halt got %b want 1", halt);
    end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0; req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 4'b0000) begin
        n_err++; $display("FAIL halt_blocks[%0d] got %b want 0000", c, req_ready);
      end
      tick();
    end
    clear_halt = 1;
    tick();
    clear_halt = 0;
    #1;
    n_vec++;
    if (halt !== 1'b0 || req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL clear_regrant got h=%b rdy=%b want 0/1000", halt, req_ready);
    end
    tick();
    req_valid = '0; eng_in_ready = 1;
    tick();
    eng_in_ready = 0; eng_out_valid = 1; eng_allow = 1;
    tick();
    eng_out_valid = 0; eng_allow = 0;
    #1;
    n_vec++;
    if (rsp_valid !== 4'b1000 || rsp_allow !== 1'b1) begin
      n_err++; $display("FAIL regrant_rsp got %b a=%b want 1000/1", rsp_valid, rsp_allow);
    end
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = '0;
  endtask

  task automatic test_timeout();
    req_valid = 4'b0001;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL tmo_req_ready got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0; eng_in_ready = 1;
    for (int c = 0; c < 15; c++) tick();
    #1;
    n_vec++;
    if (rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL tmo_early got %b want 0000", rsp_valid);
    end
    tick();
    #1;
    n_vec++;
    if (rsp_valid !== 4'b0001 || rsp_allow !== 1'b0 || rsp_kill !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_rsp got v=%b a=%b k=%b want 0001/0/1",
               rsp_valid, rsp_allow, rsp_kill);
    end
    n_vec++;
    if (timeout_err !== 1'b1 || halt !== 1'b1) begin
      n_err++; $display("FAIL tmo_flags got t=%b h=%b want 1/1", timeout_err, halt);
    end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0; eng_in_ready = 0;
    eng_out_valid = 1; eng_allow = 1;
    #1;
    n_vec++;
    if (eng_out_ready !== 1'b1) begin
      n_err++; $display("FAIL drain_ready got %b want 1", eng_out_ready);
    end
    tick();
    eng_out_valid = 0; eng_allow = 0;
    tick();
    #1;
    n_vec++;
    if (rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL drain_routed got %b want 0000", rsp_valid);
    end
    clear_halt = 1;
    tick();
    clear_halt = 0;
    #1;
    n_vec++;
    if (timeout_err !== 1'b0 || halt !== 1'b0) begin
      n_err++; $display("FAIL tmo_clear got t=%b h=%b want 0/0", timeout_err, halt);
    end
  endtask

  task automatic test_backpressure();
    req_position[32 +: 32] = 32'hFFFE_8000;
    req_beta[32 +: 32]     = 32'h0001_4000;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    req_position[32 +: 32] = 32'hDEAD_BEEF;
    req_beta[32 +: 32]     = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (eng_in_valid !== 1'b1 || eng_position !== 32'hFFFE_8000 ||
          eng_beta !== 32'h0001_4000) begin
        n_err++;
        $display("FAIL bp_issue[%0d] got v=%b p=%h b=%h want 1/fffe8000/00014000",
                 c, eng_in_valid, eng_position, eng_beta);
      end
      tick();
    end
    eng_in_ready = 1;
    tick();
    eng_in_ready = 0; eng_out_valid = 1; eng_allow = 1;
    tick();
    eng_out_valid = 0; eng_allow = 0; req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (rsp_valid !== 4'b0010 || rsp_allow !== 1'b1 || rsp_kill !== 1'b0 ||
          req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_deliver[%0d] got v=%b a=%b k=%b rdy=%b want 0010/1/0/0000",
                 c, rsp_valid, rsp_allow, rsp_kill, req_ready);
      end
      tick();
    end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL bp_next got %b want 0001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_set_clear();
    req_valid = 4'b0100;
    tick();
    req_valid = '0; eng_in_ready = 1;
    tick();
    eng_in_ready = 0; eng_out_valid = 1; eng_kill = 1; clear_halt = 1;
    tick();
    eng_out_valid = 0; eng_kill = 0; clear_halt = 0;
    #1;
    n_vec++;
    if (halt !== 1'b1 || rsp_valid !== 4'b0100 || rsp_kill !== 1'b1) begin
      n_err++;
      $display("FAIL set_clear got h=%b v=%b k=%b want 1/0100/1",
               halt, rsp_valid, rsp_kill);
    end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_fairness();
    test_kill_halt();
    test_timeout();
    test_backpressure();
    test_set_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/risk_arbiter.md
# risk_arbiter

Round-robin arbiter that lets N strategy requesters share one `risk_engine` instance. It accepts one Q16.16 position/beta request at a time, issues it to the engine, waits for the verdict and returns `allow_trade`/`kill_switch` to the requester that made the request. It also maintains a sticky global halt, set by any kill verdict or by an engine timeout. It sits between the strategy cores and the risk engine in the order path.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..16).
- `TIMEOUT`, default 16: cycles allowed from issue to engine response (≥4).

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester request accept
- `req_position`  in  N_REQ*32  signed Q16.16 positions; requester i uses bits [32i+31:32i]
- `req_beta`  in  N_REQ*32  signed Q16.16 betas, packed the same way as `req_position`
- `rsp_valid`  out  N_REQ  per-requester response valid
- `rsp_ready`  in  N_REQ  per-requester response accept
- `rsp_allow`  out  1  allow_trade verdict, shared by all requesters; meaningful only with `rsp_valid`
- `rsp_kill`  out  1  kill_switch verdict, shared by all requesters; meaningful only with `rsp_valid`
- `eng_in_valid`  out  1  to engine `in_valid`
- `eng_in_ready`  in  1  from engine `in_ready`
- `eng_position`  out  32  to engine `position_in`
- `eng_beta`  out  32  to engine `beta_in`
- `eng_out_valid`  in  1  from engine `out_valid`
- `eng_out_ready`  out  1  to engine `out_ready`
- `eng_allow`  in  1  from engine `allow_trade`
- `eng_kill`  in  1  from engine `kill_switch`
- `grant_id`  out  clog2(N_REQ)  index of the current or last owner
- `halt`  out  1  sticky global halt
- `timeout_err`  out  1  sticky engine-timeout flag
- `clear_halt`  in  1  synchronous clear for `halt` and `timeout_err`

## Operation
The FSM has four states: IDLE, ISSUE, WAIT, DELIVER.

- **IDLE**
  - The winner is the first requester with `req_valid` set, searching from `last_grant+1` with wrap-around (`N_REQ-1` → 0).
  - `req_ready` is one-hot on the winner, combinationally. It is all-zero if `halt` is set or no request is pending.
  - On the handshake, `req_position`/`req_beta` are latched into registers, `grant_id` takes the winner index, and the FSM goes to ISSUE.
  - `eng_out_ready` is held at 1 in IDLE so stale engine responses drain. Drained responses are discarded and never routed.
- **ISSUE**
  - `eng_in_valid=1`, with `eng_position`/`eng_beta` driven from the latched registers.
  - When `eng_in_ready=1` → WAIT.
- **WAIT**
  - `eng_out_ready=1`.
  - When `eng_out_valid=1`, capture `eng_allow`/`eng_kill` → DELIVER.
- **Timeout**
  - A cycle counter is cleared when the FSM enters ISSUE and increments every cycle in ISSUE or WAIT.
  - If it reaches `TIMEOUT-1` with no response, the verdict is forced to allow=0, kill=1, `timeout_err` is set, and the FSM goes to DELIVER.
  - A response arriving in the same cycle as the timeout takes priority over the timeout.
- **DELIVER**
  - `rsp_valid[grant_id]=1`; all other `rsp_valid` bits are 0.
  - `rsp_allow`/`rsp_kill` are driven from the captured verdict.
  - When `rsp_ready[grant_id]=1`, `last_grant` takes `grant_id` and the FSM goes to IDLE.
- **Halt**
  - `halt` is set on the cycle any kill=1 verdict is captured, whether from the engine or forced by timeout.
  - `clear_halt` clears both `halt` and `timeout_err`. If a set and a clear occur in the same cycle, the set wins.
  - `halt` only blocks new grants. A transaction already in flight completes normally.
- **Arithmetic:** none in this block. Payloads pass through bit-exact.

## Timing
- **Reset values:** FSM=IDLE, `last_grant=N_REQ-1` (so requester 0 wins first), `grant_id=0`, `halt=0`, `timeout_err=0`, latched verdict=0, all `rsp_valid`=0, `eng_in_valid=0`. Resetting mid-transaction abandons it with no response to the requester.
- **Latency:**
  - `req_ready` is combinational in the same cycle as `req_valid` when the block is idle.
  - Taking the cycle of the request handshake as T, `eng_in_valid` asserts at T+1.
  - With a `risk_engine` that is ready and does not stall, `eng_out_valid` arrives at T+2 and `rsp_valid` asserts at T+3.
- **Throughput:** at most one transaction per 4 cycles.
- **Handshakes:**
  - `rsp_valid` and the verdict stay stable until `rsp_ready` is seen.
  - `eng_in_valid` and its payload stay stable until `eng_in_ready` is seen.
  - `req_ready` may toggle with `req_valid`, but only in IDLE.
- **Outputs:** all outputs other than `req_ready` are registered or decoded from the state register.

## Test plan
- **Reset and first grant:** reset, then requester 2 asserts position 0x0001_0000 with beta 0x0000_8000 → `req_ready` is 0b0100, `eng_position`=0x0001_0000 at T+1, `rsp_valid[2]` at T+3 with `rsp_allow=1` and `rsp_kill=0`.
- **Round-robin fairness:** all 4 requesters hold `req_valid` continuously and `rsp_ready` stays high → grant order is 0,1,2,3,0, each grant 4 cycles apart.
- **Kill latches halt:** the engine returns `eng_kill=1` for requester 1 → `rsp_kill=1`, `halt=1`, and afterwards `req_ready` stays 0. Pulsing `clear_halt` → the next pending request is granted.
- **Timeout:** hold `eng_in_ready=1` and never assert `eng_out_valid` → after `TIMEOUT` cycles from ISSUE, `rsp_valid` asserts with allow=0 and kill=1, and `timeout_err=1` and `halt=1`. A late `eng_out_valid` pulse in IDLE is drained, with `rsp_valid` staying 0.
- **Backpressure:**
  - Hold `eng_in_ready=0` for 3 cycles → `eng_in_valid` and its payload stay stable.
  - Hold `rsp_ready=0` for 5 cycles in DELIVER → `rsp_valid` and the verdict stay stable, and no new grant occurs.
- **Simultaneous set and clear:** `clear_halt` is asserted in the same cycle a kill verdict is captured → `halt` ends at 1.
